// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM initiator: FSM encoding, default bus
// widths and the ACCESS wait-counter width.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 8;
    localparam int CNT_W  = 4;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sram_ctrl_iobuf.sv
// Tristate bank for the shared SRAM data lines: drives io when oe is set and
// always returns the resolved bus value.
module sram_ctrl_iobuf #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] drive,
    input  logic          oe,
    output logic [DW-1:0] sample,
    inout  wire  [DW-1:0] io
);

    assign io     = oe ? drive : {DW{1'bz}};
    assign sample = io;

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready to async-SRAM initiator running SETUP/ACCESS/HOLD bus cycles.
// Define SRAM_CTRL_REQBUF_EN for a one-entry request buffer allowing HOLD->SETUP chaining.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          sram_cs,
    output logic          sram_rws,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_io
);

    state_t        state;
    cnt_t          cnt;
    logic [DW-1:0] wdata_q;
    logic          io_oe;
    logic [DW-1:0] io_in;

    logic          accept;
    logic          load;
    logic          nxt_avail;
    logic          nxt_we;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_wdata;

    assign accept = req_valid && req_ready;

`ifdef SRAM_CTRL_REQBUF_EN
    logic          buf_full;
    logic          buf_full_d;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;

    // A buffered request always precedes a fresh one; ready is low while full.
    always_comb begin
        nxt_avail = accept;
        nxt_we    = req_we;
        nxt_addr  = req_addr;
        nxt_wdata = req_wdata;
        if (buf_full) begin
            nxt_avail = 1'b1;
            nxt_we    = buf_we;
            nxt_addr  = buf_addr;
            nxt_wdata = buf_wdata;
        end
    end

    assign load = nxt_avail && (state == IDLE || state == HOLD);

    always_comb begin
        buf_full_d = buf_full;
        if (load && buf_full) begin
            buf_full_d = 1'b0;
        end else if (accept && !load) begin
            buf_full_d = 1'b1;
        end
    end
`else
    always_comb begin
        nxt_avail = accept;
        nxt_we    = req_we;
        nxt_addr  = req_addr;
        nxt_wdata = req_wdata;
    end

    assign load = nxt_avail && (state == IDLE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            io_oe     <= 1'b0;
            sram_cs   <= 1'b0;
            sram_rws  <= 1'b0;
            sram_addr <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b0;
`ifdef SRAM_CTRL_REQBUF_EN
            buf_full  <= 1'b0;
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                end
                SETUP: begin
                    state   <= ACCESS;
                    cnt     <= cnt_t'(WAIT_CYC - 1);
                    sram_cs <= 1'b1;
                    io_oe   <= sram_rws;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state     <= HOLD;
                        sram_cs   <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (!sram_rws) begin
                            rsp_rdata <= io_in;
                        end
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                HOLD: begin
                    // Releasing on this edge keeps the bus free before any read ACCESS.
                    io_oe     <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase

            if (load) begin
                state     <= SETUP;
                sram_addr <= nxt_addr;
                sram_rws  <= nxt_we;
                wdata_q   <= nxt_wdata;
                req_ready <= 1'b0;
            end

`ifdef SRAM_CTRL_REQBUF_EN
            buf_full  <= buf_full_d;
            req_ready <= !buf_full_d;
            if (accept && !load) begin
                buf_we    <= req_we;
                buf_addr  <= req_addr;
                buf_wdata <= req_wdata;
            end
`endif
        end
    end

    sram_ctrl_iobuf #(
        .DW(DW)
    ) u_iobuf (
        .drive  (wdata_q),
        .oe     (io_oe),
        .sample (io_in),
        .io     (sram_io)
    );

endmodule
